// File: rtl/mips_avalon_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mips_avalon_slave_mem                                            |
// | Brief   : Avalon-MM word RAM responder with fixed and LFSR-driven wait     |
// |           states, byte-enabled writes and a sticky protocol-error flag.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mips_avalon_slave_mem #(
  parameter int unsigned ADDR_BITS     = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES   = 1,
  parameter bit          RANDOM_STALL  = 1'b0,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         DEPTH      = 1 << ADDR_BITS;
  localparam int         IDX_HI     = ADDR_BITS + 1;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [4:0] STALL_BASE = 5'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_op_q, wr_op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        commit;

  logic [31:0] mem [DEPTH];

  // Address decode for both the live bus address and the latched one.
  logic                 req;
  logic [31:0]          off_in, off_q;
  logic                 inr_in, inr_q;
  logic [ADDR_BITS-1:0] idx_in, idx_q;
  logic [ADDR_BITS-1:0] rd_idx;
  logic                 rd_inr;
  logic [31:0]          rd_word;
  logic [4:0]           stall_load;
  logic                 lfsr_fb;

  assign req     = read | write;
  assign off_in  = address - BASE_ADDR;
  assign off_q   = addr_q - BASE_ADDR;
  // Subtracting the base wraps addresses below it to large offsets, so one
  // upper-bits test covers both ends of the window.
  assign inr_in  = (off_in >> (ADDR_BITS + 2)) == 32'd0;
  assign inr_q   = (off_q >> (ADDR_BITS + 2)) == 32'd0;
  assign idx_in  = off_in[IDX_HI:2];
  assign idx_q   = off_q[IDX_HI:2];

  // A zero-stall transfer reads straight from the bus address in IDLE;
  // otherwise the latched address is the one being served.
  assign rd_idx  = (state_q == IDLE) ? idx_in : idx_q;
  assign rd_inr  = (state_q == IDLE) ? inr_in : inr_q;
  assign rd_word = rd_inr ? mem[rd_idx] : 32'h0;

  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign stall_load = STALL_BASE + (RANDOM_STALL ? {3'b000, lfsr_q[1:0]} : 5'd0);

  // Next-state, latch and bookkeeping logic for the IDLE/STALL/ACK handshake.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_op_d  = wr_op_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    commit   = 1'b0;
    lfsr_d   = {lfsr_q[6:0], lfsr_fb};
    // Simultaneous read and write is misuse whenever it appears.
    err_d    = err_q | (read & write);

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address;
          wr_op_d = write;
          wdata_d = writedata;
          be_d    = byteenable;
          cnt_d   = stall_load;
          if ((address[1:0] != 2'b00) || !inr_in) err_d = 1'b1;
          if (stall_load == 5'd0) begin
            state_d = ACK;
            if (!write) rdata_d = rd_word;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // The initiator must hold its request steady until the ACK edge.
        if (!req || (address != addr_q) || (write != wr_op_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 5'd1) begin
          state_d = ACK;
          if (!wr_op_q) rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (wr_op_q) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
          commit   = inr_q;
        end else begin
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      wr_op_q  <= 1'b0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      cnt_q    <= 5'd0;
      lfsr_q   <= LFSR_SEED;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_op_q  <= wr_op_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Byte-lane write into the RAM; a reset in the ACK cycle cancels the commit.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign waitrequest = req && (state_q != ACK);
  assign readdata    = rdata_q;
  assign err         = err_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_avalon_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mips_avalon_slave_mem                                         |
// | Brief   : Self-checking bench for mips_avalon_slave_mem: three instances   |
// |           (1 stall, 3 stalls, random stalls) against a word-array model.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mips_avalon_slave_mem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          AB    = 4;
  localparam int          DEPTH = 1 << AB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic [31:0] addr [3];
  logic        wr   [3];
  logic        rd   [3];
  logic [31:0] wdat [3];
  logic [3:0]  be   [3];
  logic        wreq [3];
  logic [31:0] rdat [3];
  logic        err  [3];
  logic [15:0] rcnt [3];
  logic [15:0] wcnt [3];

  int waitc [3] = '{1, 3, 1};

  mips_avalon_slave_mem #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(1),
                          .RANDOM_STALL(1'b0), .RAM_INIT_FILE("")) u_d0 (
    .clk(clk), .rst(rst[0]), .address(addr[0]), .write(wr[0]), .read(rd[0]),
    .writedata(wdat[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
    .readdata(rdat[0]), .err(err[0]), .rd_count(rcnt[0]), .wr_count(wcnt[0]));

  mips_avalon_slave_mem #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(3),
                          .RANDOM_STALL(1'b0), .RAM_INIT_FILE("")) u_d1 (
    .clk(clk), .rst(rst[1]), .address(addr[1]), .write(wr[1]), .read(rd[1]),
    .writedata(wdat[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
    .readdata(rdat[1]), .err(err[1]), .rd_count(rcnt[1]), .wr_count(wcnt[1]));

  mips_avalon_slave_mem #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(1),
                          .RANDOM_STALL(1'b1), .RAM_INIT_FILE("")) u_d2 (
    .clk(clk), .rst(rst[2]), .address(addr[2]), .write(wr[2]), .read(rd[2]),
    .writedata(wdat[2]), .byteenable(be[2]), .waitrequest(wreq[2]),
    .readdata(rdat[2]), .err(err[2]), .rd_count(rcnt[2]), .wr_count(wcnt[2]));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one word array per instance plus counters and error flag.
  logic [31:0] mm   [3][DEPTH];
  logic [15:0] mwc  [3];
  logic [15:0] mrc  [3];
  logic        merr [3];

  function automatic void model_reset(input int d);
    mwc[d]  = 16'h0;
    mrc[d]  = 16'h0;
    merr[d] = 1'b0;
  endfunction

  function automatic logic [31:0] model_xfer(input int d, input bit w, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [3:0] b);
    longint      off;
    bit          inr;
    int          idx;
    logic [31:0] res;
    logic [1:0]  low;
    res = 32'h0;
    low = a[1:0];
    off = longint'(a) - longint'(BASE);
    inr = (off >= 0) && (off < 4 * DEPTH);
    idx = inr ? int'(off / 4) : 0;
    if (low != 2'b00 || !inr) merr[d] = 1'b1;
    if (w) begin
      mwc[d] = mwc[d] + 16'd1;
      if (inr)
        for (int k = 0; k < 4; k++)
          if (b[k]) mm[d][idx][8*k +: 8] = wd[8*k +: 8];
    end else begin
      mrc[d] = mrc[d] + 16'd1;
      if (inr) res = mm[d][idx];
    end
    return res;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic check_wait(input int d, input int nw);
    n_chk++;
    if (d == 2) begin
      if (nw < 2 || nw > 5) begin
        n_fail++;
        $display("FAIL wait_d2: waitrequest high %0d cycles, required 2..5", nw);
      end
    end else if (nw != waitc[d] + 1) begin
      n_fail++;
      $display("FAIL wait_d%0d: waitrequest high %0d cycles, required %0d", d, nw, waitc[d] + 1);
    end
  endtask

  task automatic start(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
    addr[d] = a;
    wr[d]   = w;
    rd[d]   = !w;
    wdat[d] = wd;
    be[d]   = b;
  endtask

  // Called at a falling edge; returns inside the ACK cycle.
  task automatic wait_ack(input int d, output logic [31:0] data, output int nw);
    nw   = 0;
    data = 32'h0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!wreq[d]) begin
        data = rdat[d];
        return;
      end
      nw++;
      @(negedge clk);
    end
    n_chk++;
    n_fail++;
    $display("FAIL ack_timeout_d%0d: waitrequest still high after 100 cycles, required low", d);
  endtask

  task automatic run(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] got);
    logic [31:0] exp;
    int          nw;
    exp = model_xfer(d, w, a, wd, b);
    @(negedge clk);
    start(d, w, a, wd, b);
    wait_ack(d, got, nw);
    if (!w) check($sformatf("rdata_d%0d_%h", d, a), got, exp);
    check_wait(d, nw);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    wr[d] = 1'b0;
    rd[d] = 1'b0;
  endtask

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    wr[d]  = 1'b0;
    rd[d]  = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
    model_reset(d);
  endtask

  task automatic check_status(input int d);
    check($sformatf("wr_count_d%0d", d), 32'(wcnt[d]), 32'(mwc[d]));
    check($sformatf("rd_count_d%0d", d), 32'(rcnt[d]), 32'(mrc[d]));
    check($sformatf("err_d%0d", d), 32'(err[d]), 32'(merr[d]));
  endtask

  typedef struct {
    bit          w;
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          chk_cnt;
    int          exp_wc;
    int          exp_rc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          nw;

    tbl[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 32'h0000_0008, 32'h0000_00AA, 4'h1, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, 1'b1, 2, 1};
    tbl[3]  = '{1'b1, 32'h0000_000C, 32'h1122_3344, 4'hF, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h1122_3344, 1'b0, 1'b0, 0, 0};
    tbl[6]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 32'h0000_0004, 32'h0000_7700, 4'h2, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hCAFE_770D, 1'b0, 1'b1, 6, 3};
    tbl[9]  = '{1'b1, 32'h0000_003C, 32'h5A5A_5A5A, 4'hF, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h5A5A_5A5A, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'h0,         1'b0, 1'b0, 0, 0};
    tbl[12] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 0, 0};
    tbl[13] = '{1'b1, 32'h0000_0040, 32'h7777_7777, 4'hF, 32'h0,         1'b1, 1'b1, 9, 5};
    tbl[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b1, 1'b0, 0, 0};
    tbl[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 0, 0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      start(d, 1'b0, BASE, 32'h0, 4'h0);
      rd[d] = 1'b0;
      model_reset(d);
      for (int i = 0; i < DEPTH; i++) mm[d][i] = 32'h0;
    end
    // Instance 0 holds a write request through reset.
    start(0, 1'b1, BASE + 32'h10, 32'h0BAD_F00D, 4'hF);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #1;
    check("reset_waitreq_d0", 32'(wreq[0]), 32'h1);
    check("reset_waitreq_d1", 32'(wreq[1]), 32'h0);
    check("reset_rdata_d0", rdat[0], 32'h0);
    for (int d = 0; d < 3; d++) check_status(d);
    got = model_xfer(0, 1'b1, BASE + 32'h10, 32'h0BAD_F00D, 4'hF);
    wait_ack(0, got, nw);
    check("reset_ack_latency_d0", 32'(nw), 32'd2);

    // Fill every word of every instance so later reads have known contents.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < DEPTH; i++) run(d, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, got);
      idle(d);
    end

    // Directed table on instance 0 after a fresh reset (RAM keeps its contents).
    reset_dut(0);
    for (int i = 0; i < 16; i++) begin
      run(0, tbl[i].w, BASE + tbl[i].off, tbl[i].wd, tbl[i].be, got);
      if (!tbl[i].w) check($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(err[0]), 32'(tbl[i].exp_err));
      if (tbl[i].chk_cnt) begin
        idle(0);
        #1;
        check($sformatf("tbl%0d_wr_count", i), 32'(wcnt[0]), 32'(tbl[i].exp_wc));
        check($sformatf("tbl%0d_rd_count", i), 32'(rcnt[0]), 32'(tbl[i].exp_rc));
      end
    end
    idle(0);

    // Misaligned read after reset: word address used, error raised.
    reset_dut(0);
    #1;
    check("misalign_err_before", 32'(err[0]), 32'h0);
    run(0, 1'b0, BASE + 32'h5, 32'h0, 4'h0, got);
    check("misalign_rdata", got, 32'hCAFE_770D);
    check("misalign_err", 32'(err[0]), 32'h1);
    idle(0);

    // Three-stall instance: back-to-back reads.
    run(1, 1'b0, BASE, 32'h0, 4'h0, got);
    run(1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, got);
    idle(1);

    // Request dropped mid-STALL: error, nothing committed.
    @(negedge clk);
    start(1, 1'b1, BASE + 32'h20, 32'h1357_9BDF, 4'hF);
    @(negedge clk);
    @(negedge clk);
    wr[1] = 1'b0;
    @(negedge clk);
    #1;
    merr[1] = 1'b1;
    check_status(1);
    run(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, got);
    idle(1);

    // Reset mid-STALL: transfer aborted, counts cleared.
    @(negedge clk);
    start(1, 1'b1, BASE + 32'h24, 32'h2468_ACE0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    wr[1]  = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    #1;
    check_status(1);
    run(1, 1'b0, BASE + 32'h24, 32'h0, 4'h0, got);
    idle(1);

    // Random-stall instance: write-buffer burst of 8 then in-order readback.
    reset_dut(2);
    for (int i = 0; i < 8; i++) run(2, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, got);
    idle(2);
    #1;
    check("burst_wr_count_d2", 32'(wcnt[2]), 32'd8);
    for (int i = 0; i < 8; i++) run(2, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, got);
    idle(2);

    // Randomized mixed traffic with random byte enables.
    for (int d = 0; d < 3; d += 2) begin
      for (int n = 0; n < 30; n++) begin
        run(d, 1'($urandom_range(0, 1)), BASE + 32'(4 * $urandom_range(0, DEPTH - 1)),
            $urandom, 4'($urandom_range(0, 15)), got);
      end
      idle(d);
    end
    #1;
    for (int d = 0; d < 3; d++) check_status(d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
